// File: rtl/ifu_pc.sv
// Program-counter stage: holds the PC, selects the next PC and fences fetch
// to the instruction-memory window, halting on an illegal target.
module ifu_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_LAST  = 32'h0000_3FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [9:0]  im_addr,
  output logic        addr_err,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] pc4_w;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        legal;

  assign pc4_w  = pc_q + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = pc4_w;
    unique case (npc_op)
      2'b00: target = pc4_w;
      2'b01: target = br_taken ? (pc4_w + br_off) : pc4_w;
      2'b10: target = {pc4_w[31:28], imm26, 2'b00};
      2'b11: target = ra;
      default: target = pc4_w;
    endcase
  end

  assign legal = (target[1:0] == 2'b00) && (target >= PC_RESET) && (target <= PC_LAST);

  // Legality only matters when an update is actually attempted; a stall never faults.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (state_q == StRun && en) begin
      if (legal) begin
        pc_d = target;
        if (cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end
      end else begin
        err_d   = 1'b1;
        state_d = StHalt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= PC_RESET;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign pc        = pc_q;
  assign pc4       = pc4_w;
  assign im_addr   = pc_q[11:2];
  assign addr_err  = err_q;
  assign halted    = (state_q == StHalt);
  assign fetch_cnt = cnt_q;

endmodule
